mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 18 +
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder_array.sv | 39 +++
 rtl/mem_responder.sv | 133 +++++++++++++
 tb/tb_mem_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and default sizing for the memory responder slice.
// The package is mem_pkg so that the responder, its storage and its bus interface all share one state type.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_e;

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_WAIT_STATES = 0;
  localparam int MAX_WAIT_STATES = 15;
  localparam int CNT_WIDTH       = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and the memory responder (slave).
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) ();

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  err;
  logic                  busy;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ready, err, busy
  );

endinterface

// File: rtl/mem_responder_array.sv
// Single-port word storage with synchronous byte-enabled write and registered read.
// Contents are deliberately never reset; the read register only moves on reads.
module mem_resp_array
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BE_WIDTH    = DATA_WIDTH / 8,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request at a time, waits WAIT_STATES cycles,
// then performs the access and pulses ready with an out-of-range flag.
module mem_responder
  import mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    BE_WIDTH    = DATA_WIDTH / 8,
  parameter int                    DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = DEF_WAIT_STATES
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);

  localparam int OFF_BITS = $clog2(BE_WIDTH);
  localparam int AW       = $clog2(DEPTH_WORDS);
  localparam logic [CNT_WIDTH-1:0] CNT_INIT =
    CNT_WIDTH'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH_WORDS);

  mem_resp_state_e       state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic                  ready_q;
  logic                  err_q;
  logic                  busy_q;
  logic                  rdValid_q;

  logic                  useLive;
  logic                  opWe;
  logic [ADDR_WIDTH-1:0] opAddr;
  logic [DATA_WIDTH-1:0] opWdata;
  logic [BE_WIDTH-1:0]   opBe;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic                  inRange;
  logic                  respEnter;
  logic                  memEn;
  logic [DATA_WIDTH-1:0] arrRdata;

  // With zero wait states the access happens on the acceptance edge, before
  // the capture registers are loaded, so the live bus fields are used in IDLE.
  always_comb begin
    useLive   = (state_q == IDLE);
    opWe      = useLive ? bus.we    : we_q;
    opAddr    = useLive ? bus.addr  : addr_q;
    opWdata   = useLive ? bus.wdata : wdata_q;
    opBe      = useLive ? bus.be    : be_q;
    offset    = opAddr - BASE_ADDR;
    wordIdx   = offset >> OFF_BITS;
    inRange   = (opAddr >= BASE_ADDR) && ({1'b0, wordIdx} < DEPTH_L);
    respEnter = ((state_q == IDLE) && bus.req && (WAIT_STATES == 0)) ||
                ((state_q == WAIT) && (cnt_q == '0));
    memEn     = !rst && respEnter && inRange;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdValid_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            be_q    <= bus.be;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_INIT;
            state_q <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // Out-of-range reads zero the visible rdata; writes leave it untouched.
      if (respEnter) begin
        ready_q <= 1'b1;
        err_q   <= !inRange;
        if (!opWe) begin
          rdValid_q <= inRange;
        end
      end
    end
  end

  mem_resp_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk_i  (clk),
    .en_i   (memEn),
    .we_i   (opWe),
    .addr_i (wordIdx[AW-1:0]),
    .wdata_i(opWdata),
    .be_i   (opBe),
    .rdata_o(arrRdata)
  );

  assign bus.rdata = rdValid_q ? arrRdata : '0;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with no wait states, one with three,
// sharing a stimulus bus selected by 'sel'.
module tb_mem_responder;
  import mem_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  int          checks = 0;
  int          fails  = 0;
  exp_t        sbQ[$];
  exp_t        mon;
  logic [31:0] mdl    [2][1024];
  logic [31:0] lastRd [2];

  mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4)) bus0 ();
  mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4)) bus3 ();

  assign bus0.req   = req && !sel;
  assign bus0.we    = we;
  assign bus0.addr  = addr;
  assign bus0.wdata = wdata;
  assign bus0.be    = be;
  assign bus3.req   = req && sel;
  assign bus3.we    = we;
  assign bus3.addr  = addr;
  assign bus3.wdata = wdata;
  assign bus3.be    = be;

  mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .DEPTH_WORDS(1024),
    .BASE_ADDR(32'h0), .WAIT_STATES(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .DEPTH_WORDS(1024),
    .BASE_ADDR(32'h0), .WAIT_STATES(3)
  ) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  wire        readyM = sel ? bus3.ready : bus0.ready;
  wire        errM   = sel ? bus3.err   : bus0.err;
  wire        busyM  = sel ? bus3.busy  : bus0.busy;
  wire [31:0] rdataM = sel ? bus3.rdata : bus0.rdata;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Pushes the predicted response, issues one request and checks its latency.
  task automatic applyStimulus(input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] b);
    int   s;
    int   lat;
    logic inR;
    exp_t e;
    s   = sel ? 1 : 0;
    inR = (a < 32'h1000);
    if (w && inR) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) mdl[s][a[11:2]][8*i +: 8] = d[8*i +: 8];
      end
    end
    if (!w) lastRd[s] = inR ? mdl[s][a[11:2]] : 32'h0;
    e.err   = !inR;
    e.rdata = lastRd[s];
    sbQ.push_back(e);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    while (!readyM && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, sel ? 4 : 1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && readyM) begin
      if (sbQ.size() == 0) begin
        checkOutput("spurious_ready", readyM, 1'b0);
      end else begin
        mon = sbQ.pop_front();
        checkOutput("resp_err", errM, mon.err);
        checkOutput("resp_rdata", rdataM, mon.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; req = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; be = '0;
    lastRd[0] = '0; lastRd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready0", bus0.ready, 1'b0);
    checkOutput("rst_err0",   bus0.err,   1'b0);
    checkOutput("rst_busy0",  bus0.busy,  1'b0);
    checkOutput("rst_rdata0", bus0.rdata, 32'h0);
    checkOutput("rst_ready3", bus3.ready, 1'b0);
    checkOutput("rst_busy3",  bus3.busy,  1'b0);
    checkOutput("rst_rdata3", bus3.rdata, 32'h0);
    // A request raised during reset must not be accepted.
    req = 1'b1; sel = 1'b1; we = 1'b0; addr = 32'h0;
    @(posedge clk); #1;
    checkOutput("rst_req_ignored", bus3.busy, 1'b0);
    req = 1'b0; sel = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] zero-wait write/read, byte enables");
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF);
    applyStimulus(1'b1, 32'h10, 32'h11223344, 4'h5);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF);
    applyStimulus(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
    applyStimulus(1'b0, 32'h12, 32'h0, 4'hF);
    checkOutput("be_merge", rdataM, 32'hDE22BE44);

    $display("[TB] range checks");
    applyStimulus(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF);
    applyStimulus(1'b1, 32'h1000, 32'h99999999, 4'hF);
    applyStimulus(1'b0, 32'h1000, 32'h0, 4'hF);
    applyStimulus(1'b0, 32'hFFFFFFFC, 32'h0, 4'hF);
    applyStimulus(1'b0, 32'hFFC, 32'h0, 4'hF);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'hF);
    applyStimulus(1'b1, 32'h4, 32'h0BADCAFE, 4'hF);

    $display("[TB] back-to-back and random mix");
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      applyStimulus(1'b1, 32'h44, 32'h01020304, 4'hF);
      applyStimulus(1'b0, 32'h44, 32'h0, 4'hF);
      for (int k = 64; k < 72; k++) applyStimulus(1'b1, k * 4, $urandom, 4'hF);
      for (int n = 0; n < 16; n++) begin
        applyStimulus(1'($urandom_range(0, 1)),
                      32'($urandom_range(64, 71) * 4 + $urandom_range(0, 3)),
                      $urandom, 4'($urandom_range(0, 15)));
      end
    end

    $display("[TB] wait-state timing with ignored requests");
    sel = 1'b1;
    applyStimulus(1'b1, 32'h30, 32'h55AA55AA, 4'hF);
    lastRd[1] = mdl[1][12];
    mon.err = 1'b0; mon.rdata = lastRd[1];
    sbQ.push_back(mon);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h30; be = 4'hF;
    @(posedge clk); #1;
    we = 1'b1; wdata = 32'hBAD0BAD0;
    for (int j = 1; j <= 4; j++) begin
      checkOutput("busy_window", busyM, 1'b1);
      checkOutput("ready_timing", readyM, (j == 4));
      if (j == 4) req = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("busy_after", busyM, 1'b0);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'hF);

    $display("[TB] reset during wait");
    applyStimulus(1'b1, 32'h20, 32'h12345678, 4'hF);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    lastRd[0] = '0; lastRd[1] = '0;
    checkOutput("abort_busy", busyM, 1'b0);
    checkOutput("abort_rdata", rdataM, 32'h0);
    for (int j = 0; j < 6; j++) begin
      checkOutput("abort_no_ready", readyM, 1'b0);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF);
    checkOutput("abort_prior", rdataM, 32'h12345678);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_empty", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
